// File: rtl/seg14_pkg.sv
// Shared constants for the 14-segment display readback block: segment
// patterns (active-low), bus widths, FSM states and select-decode helpers.
package seg14_pkg;

    localparam int SEG_W = 15;
    localparam int DIG_N = 4;

    // Active-low segment words as driven by the display decoder
    localparam logic [SEG_W-1:0] SEG_0 = 15'b0000_0011_1111_111;
    localparam logic [SEG_W-1:0] SEG_1 = 15'b1001_1111_1111_111;
    localparam logic [SEG_W-1:0] SEG_2 = 15'b0010_0100_1111_111;
    localparam logic [SEG_W-1:0] SEG_3 = 15'b0000_1100_1111_111;
    localparam logic [SEG_W-1:0] SEG_4 = 15'b1001_1000_1111_111;
    localparam logic [SEG_W-1:0] SEG_5 = 15'b0100_1000_1111_111;
    localparam logic [SEG_W-1:0] SEG_6 = 15'b0100_0000_1111_111;
    localparam logic [SEG_W-1:0] SEG_7 = 15'b0001_1111_1111_111;
    localparam logic [SEG_W-1:0] SEG_8 = 15'b0000_0000_1111_111;
    localparam logic [SEG_W-1:0] SEG_9 = 15'b0000_1000_1111_111;
    localparam logic [SEG_W-1:0] SEG_F = 15'b0111_0000_1111_111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    // Exactly one digit select driven low
    function automatic logic sel_onehot(input logic [DIG_N-1:0] sel_n);
        return $countones(~sel_n) == 1;
    endfunction

    // Two or more selects low at once: bus fault, frame is aborted
    function automatic logic sel_multi(input logic [DIG_N-1:0] sel_n);
        return $countones(~sel_n) > 1;
    endfunction

    // Position of the low select bit (meaningful only when one-hot)
    function automatic logic [1:0] sel_index(input logic [DIG_N-1:0] sel_n);
        logic [1:0] idx;
        idx = '0;
        for (int i = 0; i < DIG_N; i++)
            if (!sel_n[i]) idx = 2'(i);
        return idx;
    endfunction

endpackage

// File: rtl/seg14_to_bcd.sv
// Segment word to BCD nibble. Blank-F word is a legal 4'hF; anything
// outside the table also reads 4'hF but flags err.
module seg14_to_bcd
    import seg14_pkg::*;
(
    input  logic [SEG_W-1:0] seg_i,
    output logic [3:0]       bcd_o,
    output logic             err_o
);

    // Table lookup; default covers unknown patterns
    always_comb begin
        bcd_o = 4'hF;
        err_o = 1'b0;
        case (seg_i)
            SEG_0:   bcd_o = 4'h0;
            SEG_1:   bcd_o = 4'h1;
            SEG_2:   bcd_o = 4'h2;
            SEG_3:   bcd_o = 4'h3;
            SEG_4:   bcd_o = 4'h4;
            SEG_5:   bcd_o = 4'h5;
            SEG_6:   bcd_o = 4'h6;
            SEG_7:   bcd_o = 4'h7;
            SEG_8:   bcd_o = 4'h8;
            SEG_9:   bcd_o = 4'h9;
            SEG_F:   bcd_o = 4'hF;
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg14_scan_reader.sv
// Samples a multiplexed 4-digit 14-segment bus, captures each digit once
// per select dwell after it has been stable, and publishes full frames
// through a valid/ack handshake with a sticky overrun flag.
module seg14_scan_reader
    import seg14_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEG_W-1:0] display,
    input  logic [DIG_N-1:0] ssd_ctl,
    output logic [15:0]      bcd_out,
    output logic [DIG_N-1:0] digit_err,
    output logic             out_valid,
    input  logic             out_ack,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYCLES - 1);

    logic [SEG_W+DIG_N-1:0]  prev_q;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    state_e                  state_q, state_d;
    logic [DIG_N-1:0][3:0]   shadow_q;
    logic [DIG_N-1:0]        shadow_err_q;
    logic [DIG_N-1:0]        cap_mask_q, cap_mask_d;
    logic [15:0]             bcd_q;
    logic [DIG_N-1:0]        digit_err_q;
    logic                    valid_q, overrun_q;

    logic       same, sel_chg, onehot, multi, capture, frame_done;
    logic [1:0] idx;
    logic [3:0] dec_bcd;
    logic       dec_err;

    assign same       = ({display, ssd_ctl} == prev_q);
    assign sel_chg    = (ssd_ctl != prev_q[DIG_N-1:0]);
    assign onehot     = sel_onehot(ssd_ctl);
    assign multi      = sel_multi(ssd_ctl);
    assign idx        = sel_index(ssd_ctl);
    assign frame_done = &cap_mask_q;

    seg14_to_bcd u_dec (
        .seg_i (display),
        .bcd_o (dec_bcd),
        .err_o (dec_err)
    );

    // Stability counter: restarts on any input change, saturates
    always_comb begin
        cnt_d = '0;
        if (same) cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end

    // Dwell FSM: settle on a select, capture once, hold until select moves
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE:   if (onehot) state_d = ST_SETTLE;
            ST_SETTLE: begin
                if (sel_chg || !onehot) begin
                    state_d = onehot ? ST_SETTLE : ST_IDLE;
                end else if (same && cnt_d >= CNT_CAP) begin
                    capture = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD:   if (sel_chg) state_d = onehot ? ST_SETTLE : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (multi) state_d = ST_IDLE;
    end

    // Capture mask: cleared on publish or abort, set per captured digit
    always_comb begin
        cap_mask_d = cap_mask_q;
        if (frame_done || multi) cap_mask_d = '0;
        else if (capture)        cap_mask_d[idx] = 1'b1;
    end

    // Input history, counter, state and mask registers
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q     <= '1;
            cnt_q      <= '0;
            state_q    <= ST_IDLE;
            cap_mask_q <= '0;
        end else begin
            prev_q     <= {display, ssd_ctl};
            cnt_q      <= cnt_d;
            state_q    <= state_d;
            cap_mask_q <= cap_mask_d;
        end
    end

    // Shadow digit slots; a re-capture simply overwrites the slot
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q     <= '1;
            shadow_err_q <= '0;
        end else if (capture) begin
            shadow_q[idx]     <= dec_bcd;
            shadow_err_q[idx] <= dec_err;
        end
    end

    // Output frame and handshake; completion wins over a same-cycle ack
    always_ff @(posedge clk) begin
        if (rst) begin
            bcd_q       <= 16'hFFFF;
            digit_err_q <= '0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else if (frame_done) begin
            bcd_q       <= shadow_q;
            digit_err_q <= shadow_err_q;
            valid_q     <= 1'b1;
            if (valid_q && !out_ack) overrun_q <= 1'b1;
        end else if (valid_q && out_ack) begin
            valid_q     <= 1'b0;
        end
    end

    assign bcd_out   = bcd_q;
    assign digit_err = digit_err_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg14_scan_reader.sv
// Bench for seg14_scan_reader: table-driven frames, directed corner
// sequences and a randomized run, all checked against a run-length
// reference model of the readback rules.
module tb_seg14_scan_reader;

    localparam int STABLE = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [14:0] display = 15'h7FFF;
    logic [3:0]  ssd_ctl = 4'hF;
    logic        out_ack = 1'b0;
    logic [15:0] bcd_out;
    logic [3:0]  digit_err;
    logic        out_valid, overrun;

    always #5 clk = ~clk;

    seg14_scan_reader #(.STABLE_CYCLES(STABLE), .CNT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .display   (display),
        .ssd_ctl   (ssd_ctl),
        .bcd_out   (bcd_out),
        .digit_err (digit_err),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .overrun   (overrun)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [14:0] pat [11];
    logic [3:0]  pat_val [11];

    // ---------------- reference model ----------------
    logic [18:0] m_prev;
    int          m_run;
    bit          m_took;
    logic [3:0]  m_sh [4];
    logic        m_sherr [4];
    logic [3:0]  m_mask;
    bit          m_pend;
    logic [15:0] m_bcd;
    logic [3:0]  m_err;
    logic        m_valid, m_ovr;

    task automatic decode(input logic [14:0] w, output logic [3:0] v, output logic e);
        v = 4'hF; e = 1'b1;
        for (int i = 0; i < 11; i++)
            if (w == pat[i]) begin v = pat_val[i]; e = 1'b0; end
    endtask

    task automatic model_reset();
        m_prev = '1; m_run = 0; m_took = 0; m_mask = '0; m_pend = 0;
        for (int i = 0; i < 4; i++) begin m_sh[i] = 4'hF; m_sherr[i] = 1'b0; end
        m_bcd = 16'hFFFF; m_err = '0; m_valid = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic model_step(input logic [14:0] d, input logic [3:0] s, input logic a);
        logic [18:0] vec;
        int          zeros, dig;
        logic [3:0]  v;
        logic        e;
        vec = {d, s};
        zeros = 0; dig = 0;
        for (int i = 0; i < 4; i++) if (!s[i]) begin zeros++; dig = i; end
        if (m_pend) begin
            m_bcd = {m_sh[3], m_sh[2], m_sh[1], m_sh[0]};
            m_err = {m_sherr[3], m_sherr[2], m_sherr[1], m_sherr[0]};
            if (m_valid && !a) m_ovr = 1'b1;
            m_valid = 1'b1;
            m_pend = 0;
        end else if (m_valid && a) begin
            m_valid = 1'b0;
        end
        m_run = (vec == m_prev) ? m_run + 1 : 1;
        if (s != m_prev[3:0] || zeros != 1) m_took = 0;
        if (zeros > 1) begin
            m_mask = '0;
        end else if (zeros == 1 && !m_took && m_run == STABLE) begin
            m_took = 1;
            decode(d, v, e);
            m_sh[dig] = v; m_sherr[dig] = e; m_mask[dig] = 1'b1;
            if (m_mask == 4'hF) begin m_pend = 1; m_mask = '0; end
        end
        m_prev = vec;
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic step(input logic [14:0] d, input logic [3:0] s, input logic a);
        display = d; ssd_ctl = s; out_ack = a;
        @(posedge clk); #1;
        model_step(d, s, a);
        chk("model", {10'b0, bcd_out, digit_err, out_valid, overrun},
                     {10'b0, m_bcd, m_err, m_valid, m_ovr});
    endtask

    task automatic dwell(input logic [14:0] w, input int dig, input int n, input int ack_at);
        logic [3:0] s;
        s = ~(4'b0001 << dig);
        for (int i = 0; i < n; i++) step(w, s, (i == ack_at));
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) step(15'h7FFF, 4'hF, 1'b0);
    endtask

    task automatic scan4(input logic [14:0] w3, input logic [14:0] w2,
                         input logic [14:0] w1, input logic [14:0] w0);
        dwell(w3, 3, 6, -1); gap(2);
        dwell(w2, 2, 6, -1); gap(2);
        dwell(w1, 1, 6, -1); gap(2);
        dwell(w0, 0, 6, -1); gap(2);
    endtask

    task automatic do_reset();
        rst = 1'b1; display = 15'h7FFF; ssd_ctl = 4'hF; out_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        chk("rst_state", {10'b0, bcd_out, digit_err, out_valid, overrun},
                         {10'b0, 16'hFFFF, 4'h0, 1'b0, 1'b0});
    endtask

    typedef struct {
        logic [14:0] w3, w2, w1, w0;
        logic [15:0] exp_bcd;
        logic [3:0]  exp_err;
    } frame_t;

    frame_t vec [5];

    initial begin
        pat[0] = 15'b0000_0011_1111_111; pat[1]  = 15'b1001_1111_1111_111;
        pat[2] = 15'b0010_0100_1111_111; pat[3]  = 15'b0000_1100_1111_111;
        pat[4] = 15'b1001_1000_1111_111; pat[5]  = 15'b0100_1000_1111_111;
        pat[6] = 15'b0100_0000_1111_111; pat[7]  = 15'b0001_1111_1111_111;
        pat[8] = 15'b0000_0000_1111_111; pat[9]  = 15'b0000_1000_1111_111;
        pat[10] = 15'b0111_0000_1111_111;
        for (int i = 0; i < 10; i++) pat_val[i] = 4'(i);
        pat_val[10] = 4'hF;

        vec[0] = '{pat[1], pat[2], pat[3], pat[4], 16'h1234, 4'b0000};
        vec[1] = '{pat[9], 15'h7FFF, pat[9], pat[9], 16'h9F99, 4'b0100};
        vec[2] = '{pat[10], pat[0], pat[8], pat[7], 16'hF087, 4'b0000};
        vec[3] = '{pat[5], pat[6], pat[7], pat[8], 16'h5678, 4'b0000};
        vec[4] = '{15'h0000, pat[2], 15'h1234, pat[3], 16'hF2F3, 4'b1010};

        do_reset();

        // Table frames: last digit stepped by hand to pin 1-cycle latency
        for (int k = 0; k < 5; k++) begin
            dwell(vec[k].w3, 3, 6, -1); gap(2);
            dwell(vec[k].w2, 2, 6, -1); gap(2);
            dwell(vec[k].w1, 1, 6, -1); gap(2);
            dwell(vec[k].w0, 0, STABLE, -1);
            chk("lat_before", 32'(out_valid), 32'd0);
            step(vec[k].w0, 4'b1110, 1'b0);
            chk("lat_valid", 32'(out_valid), 32'd1);
            chk("tbl_bcd", 32'(bcd_out), 32'(vec[k].exp_bcd));
            chk("tbl_err", 32'(digit_err), 32'(vec[k].exp_err));
            step(15'h7FFF, 4'hF, 1'b1);
            chk("ack_clear", 32'(out_valid), 32'd0);
            gap(2);
        end
        chk("no_ovr_acked", 32'(overrun), 32'd0);

        // Ack while idle is ignored
        step(15'h7FFF, 4'hF, 1'b1);
        chk("idle_ack", 32'(out_valid), 32'd0);

        // Short dwell on digit1 captures nothing
        do_reset();
        dwell(pat[1], 3, 6, -1); gap(2);
        dwell(pat[2], 2, 6, -1); gap(2);
        dwell(pat[3], 1, STABLE - 1, -1); gap(2);
        dwell(pat[4], 0, 6, -1); gap(2);
        chk("short_novalid", 32'(out_valid), 32'd0);
        dwell(pat[3], 1, STABLE, -1);
        step(15'h7FFF, 4'hF, 1'b0);
        chk("short_valid", 32'(out_valid), 32'd1);
        chk("short_bcd", 32'(bcd_out), 32'h1234);

        // Two frames without ack -> overrun
        do_reset();
        scan4(pat[5], pat[6], pat[7], pat[8]);
        chk("f1_bcd", 32'(bcd_out), 32'h5678);
        scan4(pat[0], pat[0], pat[0], pat[0]);
        chk("ovr_bcd", 32'(bcd_out), 32'h0000);
        chk("ovr_flag", 32'(overrun), 32'd1);
        chk("ovr_valid", 32'(out_valid), 32'd1);

        // Ack in the completion cycle: new frame, no overrun
        do_reset();
        scan4(pat[1], pat[2], pat[3], pat[4]);
        dwell(pat[8], 3, 6, -1); gap(2);
        dwell(pat[7], 2, 6, -1); gap(2);
        dwell(pat[6], 1, 6, -1); gap(2);
        dwell(pat[5], 0, 6, STABLE);
        chk("sameack_valid", 32'(out_valid), 32'd1);
        chk("sameack_ovr", 32'(overrun), 32'd0);
        chk("sameack_bcd", 32'(bcd_out), 32'h8765);

        // Reset after two captures discards them
        do_reset();
        dwell(pat[9], 3, 6, -1); gap(2);
        dwell(pat[9], 2, 6, -1); gap(2);
        do_reset();
        dwell(pat[2], 1, 6, -1); gap(2);
        dwell(pat[1], 0, 6, -1); gap(2);
        chk("rst_nostale", 32'(out_valid), 32'd0);
        dwell(pat[4], 3, 6, -1); gap(2);
        dwell(pat[3], 2, 6, -1); gap(2);
        chk("rst_bcd", 32'(bcd_out), 32'h4321);
        chk("rst_valid", 32'(out_valid), 32'd1);

        // Multiple selects low abort the partial frame
        do_reset();
        dwell(pat[7], 3, 6, -1); gap(2);
        dwell(pat[7], 2, 6, -1);
        step(pat[8], 4'b0011, 1'b0); step(pat[8], 4'b0011, 1'b0);
        gap(2);
        dwell(pat[4], 1, 6, -1); gap(2);
        dwell(pat[3], 0, 6, -1); gap(2);
        chk("abort_novalid", 32'(out_valid), 32'd0);
        dwell(pat[6], 3, 6, -1); gap(2);
        dwell(pat[5], 2, 6, -1); gap(2);
        chk("abort_bcd", 32'(bcd_out), 32'h6543);

        // Randomized scan traffic against the model
        do_reset();
        for (int it = 0; it < 700; it++) begin
            int          kind, n;
            logic [3:0]  s;
            logic [14:0] w;
            kind = int'($urandom_range(0, 9));
            if (kind <= 6)      s = ~(4'b0001 << $urandom_range(0, 3));
            else if (kind <= 8) s = 4'hF;
            else begin
                s = 4'($urandom);
                while ($countones(~s) < 2) s = 4'($urandom);
            end
            w = ($urandom_range(0, 9) < 8) ? pat[$urandom_range(0, 10)] : 15'($urandom);
            n = int'($urandom_range(1, 7));
            for (int j = 0; j < n; j++) begin
                if ($urandom_range(0, 9) == 0) w = pat[$urandom_range(0, 10)];
                step(w, s, ($urandom_range(0, 3) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
